dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 186 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// +--------------------------------------------------------------------------+
// | dmem_responder: fixed-latency single-port data memory responder with a   |
// | valid/ready request side and a one-cycle response pulse.                 |
// | Optional feature macro: DMEM_ALIGN_CHECK_EN (misaligned word access flag) |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_byte,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
`ifdef DMEM_ALIGN_CHECK_EN
   output logic        resp_err,
`endif
   output logic [31:0] resp_rdata
);

   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam int         ADDR_W   = IDX_W + 2;
   localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic [2:0] cnt;
   logic [2:0] cnt_nxt;

   // request captured at accept; only the address bits that select a word and lane are kept
   logic              wr_q;
   logic              byte_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic             accept;
   logic             perform;
   logic             misaligned;
   logic             mem_we;
   logic [IDX_W-1:0] idx;
   logic [1:0]       lane;
   logic [3:0]       lane_we;
   logic [31:0]      wdata_lanes;
   logic [31:0]      word_rd;
   logic [7:0]       byte_rd;
   logic [31:0]      load_val;

   assign idx       = addr_q[ADDR_W-1:2];
   assign lane      = addr_q[1:0];
   assign req_ready = reset && (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign perform   = (state == BUSY) && (cnt == 3'd0);

`ifdef DMEM_ALIGN_CHECK_EN
   logic err_q;
   assign misaligned = !byte_q && (lane != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = BUSY;
               cnt_nxt   = CNT_LOAD;
            end
         end
         BUSY: begin
            if (cnt == 3'd0) begin
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt - 3'd1;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
         end
      endcase
   end

   // ---------------------------------------------------------------- request latch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q    <= 1'b0;
         byte_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         wr_q    <= req_write;
         byte_q  <= req_byte;
         addr_q  <= req_addr[ADDR_W-1:0];
         wdata_q <= req_wdata;
      end
   end

   // ---------------------------------------------------------------- memory
   assign mem_we      = perform && wr_q && !misaligned;
   assign lane_we     = byte_q ? (4'b0001 << lane) : 4'b1111;
   assign wdata_lanes = byte_q ? {4{wdata_q[7:0]}} : wdata_q;

   // no reset here: contents survive reset by design
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_we[b]) begin
               mem[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
            end
         end
      end
   end

   assign word_rd = mem[idx];

   always_comb begin
      byte_rd = word_rd[7:0];
      case (lane)
         2'd0:    byte_rd = word_rd[7:0];
         2'd1:    byte_rd = word_rd[15:8];
         2'd2:    byte_rd = word_rd[23:16];
         default: byte_rd = word_rd[31:24];
      endcase
   end

   assign load_val = byte_q ? {{24{byte_rd[7]}}, byte_rd} : word_rd;

   // ---------------------------------------------------------------- response
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
      end else if (perform) begin
         rdata_q <= (wr_q || misaligned) ? 32'd0 : load_val;
      end
   end

   assign resp_valid = (state == RESP);
   assign resp_rdata = resp_valid ? rdata_q : 32'd0;

`ifdef DMEM_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (perform) begin
         err_q <= misaligned;
      end
   end

   assign resp_err = resp_valid && err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// +--------------------------------------------------------------------------+
// | tb_dmem_responder: directed self-checking bench for dmem_responder.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dmem_responder;

   localparam int DEPTH_WORDS = 64;
   localparam int LATENCY     = 2;
   localparam int EXP_LAT     = LATENCY + 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic        req_byte;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
   logic        resp_err;
`endif

   int errors = 0;
   int checks = 0;

   int          n;
   int          cyc;
   int          nacc;
   int          lows;
   int          pulses;
   int          acc_t [3];
   logic [31:0] rd;
   int          lat;
   logic        er;

   dmem_responder #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .LATENCY    (LATENCY)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_byte  (req_byte),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
`ifdef DMEM_ALIGN_CHECK_EN
      .resp_err  (resp_err),
`endif
      .resp_rdata(resp_rdata)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // called at a negedge in IDLE; returns at the negedge after the response pulse
   task automatic access(input logic wr, input logic by, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rdata,
                         output int latency, output logic err);
      int  k;
      bit  got;
      rdata     = '0;
      latency   = -1;
      err       = 1'b0;
      req_valid = 1'b1;
      req_write = wr;
      req_byte  = by;
      req_addr  = addr;
      req_wdata = wd;
      k = 0;
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) begin
         check_eq("accept_timeout", {31'd0, req_ready}, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      got = 1'b0;
      k   = 0;
      while (!got && k < 20) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            // disturb the inputs to show the in-flight access is unaffected
            req_valid = 1'b0;
            req_write = ~wr;
            req_byte  = ~by;
            req_addr  = ~addr;
            req_wdata = ~wd;
         end
         if (resp_valid) begin
            got     = 1'b1;
            latency = k;
            rdata   = resp_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
            err     = resp_err;
`endif
         end
      end
      if (!got) check_eq("resp_timeout", {31'd0, got}, 32'd1);
      @(negedge clk);
      check_eq("resp_pulse_width", {31'd0, resp_valid}, 32'd0);
   endtask

   task automatic do_store(input string tag, input logic by, input logic [31:0] addr,
                           input logic [31:0] wd);
      logic [31:0] r;
      int          l;
      logic        e;
      access(1'b1, by, addr, wd, r, l, e);
      check_eq({tag, "_lat"}, l, EXP_LAT);
      check_eq({tag, "_rdata"}, r, 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
      check_eq({tag, "_err"}, {31'd0, e}, 32'd0);
`endif
   endtask

   task automatic do_load(input string tag, input logic by, input logic [31:0] addr,
                          input logic [31:0] exp);
      logic [31:0] r;
      int          l;
      logic        e;
      access(1'b0, by, addr, 32'h0, r, l, e);
      check_eq({tag, "_lat"}, l, EXP_LAT);
      check_eq({tag, "_rdata"}, r, exp);
`ifdef DMEM_ALIGN_CHECK_EN
      check_eq({tag, "_err"}, {31'd0, e}, 32'd0);
`endif
   endtask

   initial begin
      reset     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_byte  = 1'b0;
      req_addr  = '0;
      req_wdata = '0;

      // reset state
      repeat (3) @(negedge clk);
      check_eq("rst_ready", {31'd0, req_ready}, 32'd0);
      check_eq("rst_valid", {31'd0, resp_valid}, 32'd0);
      check_eq("rst_rdata", resp_rdata, 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
      check_eq("rst_err", {31'd0, resp_err}, 32'd0);
`endif
      reset = 1'b1;
      @(negedge clk);
      check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);

      // word store / load and byte lanes
      do_store("st_word", 1'b0, 32'h10, 32'hDEADBEEF);
      do_load ("ld_word", 1'b0, 32'h10, 32'hDEADBEEF);
      do_store("st_b12",  1'b1, 32'h12, 32'h00000080);
      do_load ("ld_w10a", 1'b0, 32'h10, 32'hDE80BEEF);
      do_load ("ld_b12",  1'b1, 32'h12, 32'hFFFFFF80);
      do_load ("ld_b13",  1'b1, 32'h13, 32'hFFFFFFDE);
      do_load ("ld_b10",  1'b1, 32'h10, 32'hFFFFFFEF);
      do_store("st_b11",  1'b1, 32'h11, 32'hAAAAAA7F);
      do_load ("ld_w10b", 1'b0, 32'h10, 32'hDE807FEF);
      do_load ("ld_b11",  1'b1, 32'h11, 32'h0000007F);

      // back-to-back loads with req_valid held high
      req_valid = 1'b1;
      req_write = 1'b0;
      req_byte  = 1'b0;
      req_addr  = 32'h10;
      req_wdata = 32'h0;
      cyc  = 0;
      nacc = 0;
      lows = 0;
      while (nacc < 3 && cyc < 40) begin
         if (req_ready) begin
            acc_t[nacc] = cyc;
            nacc++;
         end else begin
            lows++;
         end
         @(negedge clk);
         cyc++;
      end
      req_valid = 1'b0;
      repeat (6) @(negedge clk);
      check_eq("b2b_accepts", nacc, 3);
      check_eq("b2b_gap01", acc_t[1] - acc_t[0], LATENCY + 2);
      check_eq("b2b_gap12", acc_t[2] - acc_t[1], LATENCY + 2);
      check_eq("b2b_ready_low", lows, 2 * (LATENCY + 1));

      // reset during BUSY aborts a store
      do_store("st_pre20", 1'b0, 32'h20, 32'hCAFEF00D);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_byte  = 1'b0;
      req_addr  = 32'h20;
      req_wdata = 32'h12345678;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check_eq("abort_busy_ready", {31'd0, req_ready}, 32'd0);
      reset = 1'b0;
      #1;
      check_eq("abort_rst_valid", {31'd0, resp_valid}, 32'd0);
      check_eq("abort_rst_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      reset  = 1'b1;
      pulses = 0;
      repeat (8) begin
         @(negedge clk);
         if (resp_valid) pulses++;
      end
      check_eq("abort_no_pulse", pulses, 0);
      do_load("ld_after_abort", 1'b0, 32'h20, 32'hCAFEF00D);

      // address wrap modulo DEPTH_WORDS*4
      do_store("st_wrap", 1'b0, 32'h104, 32'hA5A55A5A);
      do_load ("ld_wrap", 1'b0, 32'h004, 32'hA5A55A5A);

      // misaligned word store
`ifdef DMEM_ALIGN_CHECK_EN
      do_store("st_al20", 1'b0, 32'h20, 32'h0BADCAFE);
      access(1'b1, 1'b0, 32'h21, 32'h55667788, rd, lat, er);
      check_eq("mis_lat", lat, EXP_LAT);
      check_eq("mis_err", {31'd0, er}, 32'd1);
      check_eq("mis_rdata", rd, 32'd0);
      do_load("ld_mis_unchanged", 1'b0, 32'h20, 32'h0BADCAFE);
`else
      do_store("st_mis", 1'b0, 32'h21, 32'h55667788);
      do_load ("ld_mis_idx8", 1'b0, 32'h20, 32'h55667788);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
